// File: rtl/eat_event_gen.sv
// Turns per-frame player/gold and player/diamond pixel overlaps into single-cycle
// eat pulses: rising-edge per frame, with a per-type cooldown in frames.
module eat_event_gen #(
  parameter int COOLDOWN_FRAMES = 4,
  parameter int CNT_W           = 3
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       player_dr,
  input  logic       gold_dr,
  input  logic       dimond_dr,
  input  logic       enable,
  output logic       player_eat_gold,
  output logic       player_eat_dimond,
  output logic [7:0] gold_cnt
);

  localparam logic [CNT_W-1:0] CD_LOAD = CNT_W'(COOLDOWN_FRAMES);

  logic [1:0] overlap;
  logic [1:0] fire_vec;
  logic [7:0] gold_cnt_reg;

  // Index 0 is gold, index 1 is diamond; both types share identical logic.
  assign overlap = {player_dr & dimond_dr, player_dr & gold_dr};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_type
      logic             hit_reg;
      logic             prev_reg;
      logic             fire_reg;
      logic             fire_next;
      logic [CNT_W-1:0] cd_reg;

      always_comb begin
        fire_next = startOfFrame & hit_reg & ~prev_reg & (cd_reg == '0) & enable;
      end

      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          hit_reg  <= 1'b0;
          prev_reg <= 1'b0;
          fire_reg <= 1'b0;
          cd_reg   <= '0;
        end else begin
          fire_reg <= fire_next;
          if (startOfFrame) begin
            // Overlap on the strobe cycle itself belongs to neither frame.
            prev_reg <= hit_reg;
            hit_reg  <= 1'b0;
            if (fire_next) begin
              cd_reg <= CD_LOAD;
            end else if (cd_reg != '0) begin
              cd_reg <= cd_reg - CNT_W'(1);
            end
          end else if (enable) begin
            hit_reg <= hit_reg | overlap[gi];
          end
        end
      end

      assign fire_vec[gi] = fire_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      gold_cnt_reg <= 8'd0;
    end else if (fire_vec[0] && (gold_cnt_reg != 8'd255)) begin
      gold_cnt_reg <= gold_cnt_reg + 8'd1;
    end
  end

  assign player_eat_gold   = fire_vec[0];
  assign player_eat_dimond = fire_vec[1];
  assign gold_cnt          = gold_cnt_reg;

endmodule

// File: tb/tb_eat_event_gen.sv
// Self-checking bench for eat_event_gen: directed frame scenarios plus random
// frames, compared every cycle against a frame-level reference model.
module tb_eat_event_gen;

  localparam int CD = 4;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       player_dr = 1'b0;
  logic       gold_dr = 1'b0;
  logic       dimond_dr = 1'b0;
  logic       enable = 1'b0;
  logic       player_eat_gold;
  logic       player_eat_dimond;
  logic [7:0] gold_cnt;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state: one overlap flag per frame in progress, the flag of
  // the frame just closed, and the boundary number of the last event per type.
  bit f_g, f_d, pr_g, pr_d;
  int bnd;
  int last_g, last_d;
  bit exp_g, exp_d;
  int exp_cnt;
  int pulses_g;

  eat_event_gen #(.COOLDOWN_FRAMES(CD), .CNT_W(3)) dut (
    .clk              (clk),
    .resetN           (resetN),
    .startOfFrame     (startOfFrame),
    .player_dr        (player_dr),
    .gold_dr          (gold_dr),
    .dimond_dr        (dimond_dr),
    .enable           (enable),
    .player_eat_gold  (player_eat_gold),
    .player_eat_dimond(player_eat_dimond),
    .gold_cnt         (gold_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    f_g = 0; f_d = 0; pr_g = 0; pr_d = 0;
    last_g = -1000; last_d = -1000;
    exp_g = 0; exp_d = 0; exp_cnt = 0;
  endtask

  // Advances the model across the coming rising edge using the driven inputs.
  task automatic model_step();
    bit nxt_g, nxt_d;
    if (!resetN) begin
      model_reset();
    end else begin
      if (exp_g) begin
        pulses_g++;
        if (exp_cnt < 255) exp_cnt++;
      end
      nxt_g = 0;
      nxt_d = 0;
      if (startOfFrame) begin
        bnd++;
        nxt_g = f_g && !pr_g && enable && (bnd - last_g > CD);
        nxt_d = f_d && !pr_d && enable && (bnd - last_d > CD);
        if (nxt_g) last_g = bnd;
        if (nxt_d) last_d = bnd;
        pr_g = f_g; pr_d = f_d;
        f_g = 0; f_d = 0;
      end else if (enable) begin
        if (player_dr && gold_dr)   f_g = 1;
        if (player_dr && dimond_dr) f_d = 1;
      end
      exp_g = nxt_g;
      exp_d = nxt_d;
    end
  endtask

  task automatic check_outputs();
    check_eq("pulse_gold",   {31'd0, player_eat_gold},   {31'd0, exp_g});
    check_eq("pulse_dimond", {31'd0, player_eat_dimond}, {31'd0, exp_d});
    check_eq("gold_cnt",     {24'd0, gold_cnt},          exp_cnt);
  endtask

  task automatic drive(input bit rn, input bit sof, input bit p, input bit g,
                       input bit d, input bit en);
    @(negedge clk);
    check_outputs();
    resetN       = rn;
    startOfFrame = sof;
    player_dr    = p;
    gold_dr      = g;
    dimond_dr    = d;
    enable       = en;
    model_step();
  endtask

  // len pixels of the given overlaps, then the closing strobe.
  task automatic frame(input int len, input bit g, input bit d, input bit en,
                       input bit sof_ov);
    for (int i = 0; i < len; i++) drive(1, 0, 1, g, d, en);
    drive(1, 1, sof_ov, sof_ov, sof_ov, en);
  endtask

  task automatic idle_frames(input int n);
    for (int i = 0; i < n; i++) frame(2, 0, 0, 1, 0);
  endtask

  initial begin
    bnd = 0;
    pulses_g = 0;
    model_reset();

    // Reset held for a few cycles, then release.
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 1, 1, 1);
    drive(1, 0, 0, 0, 0, 1);
    $display("scenario reset: released");

    // First gold contact after reset.
    frame(10, 1, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 1);
    check_eq("first_event_cnt", {24'd0, gold_cnt}, 32'd1);
    $display("scenario first_event: gold_cnt=%0d", gold_cnt);
    idle_frames(6);

    // Sustained overlap over 8 frames gives one event.
    pulses_g = 0;
    for (int i = 0; i < 8; i++) frame(4, 1, 0, 1, 0);
    idle_frames(6);
    check_eq("sustained_pulses", pulses_g, 32'd1);
    $display("scenario sustained: pulses=%0d", pulses_g);

    // Cooldown: contact, gap, contact (blocked), gap, gap, contact (fires).
    pulses_g = 0;
    frame(3, 1, 0, 1, 0);
    frame(3, 0, 0, 1, 0);
    frame(3, 1, 0, 1, 0);
    frame(3, 0, 0, 1, 0);
    frame(3, 0, 0, 1, 0);
    frame(3, 1, 0, 1, 0);
    idle_frames(6);
    check_eq("cooldown_pulses", pulses_g, 32'd2);
    $display("scenario cooldown: pulses=%0d", pulses_g);

    // Simultaneous gold and diamond, then contact only on the strobe cycle.
    frame(3, 1, 1, 1, 0);
    idle_frames(6);
    frame(3, 0, 0, 1, 1);
    frame(3, 0, 0, 1, 0);
    idle_frames(6);
    $display("scenario simultaneous: done");

    // Asynchronous reset mid-frame after an overlap.
    drive(1, 0, 1, 1, 1, 1);
    drive(1, 0, 0, 0, 0, 1);
    @(negedge clk);
    check_outputs();
    resetN = 1'b0;
    #1;
    check_eq("async_rst_gold",   {31'd0, player_eat_gold},   32'd0);
    check_eq("async_rst_dimond", {31'd0, player_eat_dimond}, 32'd0);
    check_eq("async_rst_cnt",    {24'd0, gold_cnt},          32'd0);
    model_step();
    drive(0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 1);
    frame(2, 0, 0, 1, 0);
    $display("scenario async_reset: done");

    // enable=0 during overlap, and cooldown counting while disabled.
    frame(3, 1, 1, 0, 0);
    frame(3, 1, 0, 1, 0);
    for (int i = 0; i < 4; i++) frame(2, 0, 0, 0, 0);
    frame(3, 1, 0, 1, 0);
    idle_frames(6);
    $display("scenario enable: done");

    // Random frames, including back-to-back strobes (len 0).
    for (int f = 0; f < 300; f++) begin
      int len;
      bit en;
      len = $urandom_range(0, 6);
      en  = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < len; i++)
        drive(1, 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
              $urandom_range(0, 3) == 0, en);
      drive(1, 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, $urandom_range(0, 7) != 0);
    end
    $display("scenario random: gold_cnt=%0d", gold_cnt);

    // Saturation: more than 255 separated gold events.
    for (int e = 0; e < 260; e++) begin
      frame(1, 1, 0, 1, 0);
      idle_frames(CD + 1);
    end
    drive(1, 0, 0, 0, 0, 1);
    check_eq("saturated_cnt", {24'd0, gold_cnt}, 32'd255);
    $display("scenario saturation: gold_cnt=%0d", gold_cnt);

    @(negedge clk);
    check_outputs();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
